mini_alu_core_p: RTL and testbench



---
 rtl/mini_alu_core_p_if.sv | 12 +
 rtl/mini_alu_core_p.sv | 238 +++++++++++++++++++++++
 tb/tb_mini_alu_core_p.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mini_alu_core_p_if.sv
// Output-port handshake between the core (master) and a byte/word sink (slave).
// The payload is held stable while valid is high and ready is low.
interface mini_alu_core_p_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] oOutData;
  logic                  oOutValid;
  logic                  iOutReady;

  modport master (output oOutData, output oOutValid, input iOutReady);
  modport slave  (input oOutData, input oOutValid, output iOutReady);
endinterface

// File: rtl/mini_alu_core_p.sv
// Mini ALU core: fetch/exec from an async ROM, return-address stack, shift-add multiplier,
// and a valid/ready output port that stalls the core until the sink accepts the payload.
module mini_alu_core_p #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int IP_WIDTH    = 16,
  parameter int STACK_DEPTH = 4,
  parameter int LED_WIDTH   = 8
) (
  input  logic                               Clock,
  input  logic                               Reset,
  output logic [IP_WIDTH-1:0]                oIP,
  input  logic [4+3*ADDR_WIDTH-1:0]          iInstruction,
  output logic [LED_WIDTH-1:0]               oLed,
  output logic                               oFault,
  output logic [1:0]                         oFaultCode,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   oStackLevel,
  mini_alu_core_p_if.master                  out_if
);

  localparam int A  = ADDR_WIDTH;
  localparam int IW = 4 + 3*ADDR_WIDTH;
  localparam int LW = $clog2(STACK_DEPTH+1);
  localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CW = $clog2(DATA_WIDTH+1);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_STO  = 4'd3;
  localparam logic [3:0] OP_BLE  = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_CALL = 4'd6;
  localparam logic [3:0] OP_RET  = 4'd7;
  localparam logic [3:0] OP_LED  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_OUTI = 4'd10;
  localparam logic [3:0] OP_OUTR = 4'd11;

  localparam logic [1:0] FC_OVF = 2'b01;
  localparam logic [1:0] FC_UNF = 2'b10;
  localparam logic [1:0] FC_ILL = 2'b11;

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MUL, S_OUTW, S_FAULT} state_t;

  state_t                state_q, state_d;
  logic [IP_WIDTH-1:0]   ip_q, ip_d;
  logic [IW-1:0]         ir_q, ir_d;
  logic [LED_WIDTH-1:0]  led_q, led_d;
  logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
  logic                  out_vld_q, out_vld_d;
  logic                  fault_q, fault_d;
  logic [1:0]            fault_code_q, fault_code_d;
  logic [LW-1:0]         lvl_q, lvl_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]         mcnt_q, mcnt_d;

  logic [DATA_WIDTH-1:0] rf_q [2**ADDR_WIDTH];
  logic [IP_WIDTH-1:0]   stk_q [STACK_DEPTH];

  logic [3:0]            op;
  logic [A-1:0]          d_f, s1_f, s0_f;
  logic [DATA_WIDTH-1:0] rd1, rd0, imm;
  logic [IP_WIDTH-1:0]   ip_inc, jmp_tgt;
  logic [SW-1:0]         push_idx, pop_idx;
  logic                  rf_we, push_en;
  logic [DATA_WIDTH-1:0] rf_wd;

  assign op       = ir_q[IW-1 -: 4];
  assign d_f      = ir_q[3*A-1 : 2*A];
  assign s1_f     = ir_q[2*A-1 : A];
  assign s0_f     = ir_q[A-1 : 0];
  assign rd1      = rf_q[s1_f];
  assign rd0      = rf_q[s0_f];
  assign imm      = DATA_WIDTH'(ir_q[2*A-1 : 0]);
  assign ip_inc   = ip_q + IP_WIDTH'(1);
  assign jmp_tgt  = IP_WIDTH'(d_f);
  assign push_idx = SW'(lvl_q);
  assign pop_idx  = SW'(lvl_q - LW'(1));

  always_comb begin
    state_d      = state_q;
    ip_d         = ip_q;
    ir_d         = ir_q;
    led_d        = led_q;
    out_dat_d    = out_dat_q;
    out_vld_d    = out_vld_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    lvl_d        = lvl_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    mcnt_d       = mcnt_q;
    rf_we        = 1'b0;
    rf_wd        = '0;
    push_en      = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_d    = iInstruction;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        ip_d    = ip_inc;
        state_d = S_FETCH;
        case (op)
          OP_NOP: ;
          OP_ADD: begin rf_we = 1'b1; rf_wd = rd1 + rd0; end
          OP_SUB: begin rf_we = 1'b1; rf_wd = rd1 - rd0; end
          OP_STO: begin rf_we = 1'b1; rf_wd = imm; end
          OP_BLE: if (rd1 <= rd0) ip_d = jmp_tgt;
          OP_JMP: ip_d = jmp_tgt;
          OP_CALL: begin
            if (lvl_q == LW'(STACK_DEPTH)) begin
              ip_d         = ip_q;
              state_d      = S_FAULT;
              fault_d      = 1'b1;
              fault_code_d = FC_OVF;
            end else begin
              push_en = 1'b1;
              lvl_d   = lvl_q + LW'(1);
              ip_d    = jmp_tgt;
            end
          end
          OP_RET: begin
            if (lvl_q == '0) begin
              ip_d         = ip_q;
              state_d      = S_FAULT;
              fault_d      = 1'b1;
              fault_code_d = FC_UNF;
            end else begin
              ip_d  = stk_q[pop_idx];
              lvl_d = lvl_q - LW'(1);
            end
          end
          OP_LED: led_d = rd1[LED_WIDTH-1:0];
          OP_MUL: begin
            // Operands captured here so D may alias S0/S1.
            mcand_d  = rd1;
            mplier_d = rd0;
            acc_d    = '0;
            mcnt_d   = '0;
            ip_d     = ip_q;
            state_d  = S_MUL;
          end
          OP_OUTI: begin
            out_dat_d = imm;
            out_vld_d = 1'b1;
            ip_d      = ip_q;
            state_d   = S_OUTW;
          end
          OP_OUTR: begin
            out_dat_d = rd1;
            out_vld_d = 1'b1;
            ip_d      = ip_q;
            state_d   = S_OUTW;
          end
          default: begin
            ip_d         = ip_q;
            state_d      = S_FAULT;
            fault_d      = 1'b1;
            fault_code_d = FC_ILL;
          end
        endcase
      end
      S_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        mcnt_d   = mcnt_q + CW'(1);
        if (mcnt_q == CW'(DATA_WIDTH-1)) begin
          rf_we   = 1'b1;
          rf_wd   = acc_d;
          ip_d    = ip_inc;
          state_d = S_FETCH;
        end
      end
      S_OUTW: begin
        if (out_if.iOutReady) begin
          out_vld_d = 1'b0;
          ip_d      = ip_inc;
          state_d   = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_FETCH;
      ip_q         <= '0;
      ir_q         <= '0;
      led_q        <= '0;
      out_dat_q    <= '0;
      out_vld_q    <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
      lvl_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      mcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      ip_q         <= ip_d;
      ir_q         <= ir_d;
      led_q        <= led_d;
      out_dat_q    <= out_dat_d;
      out_vld_q    <= out_vld_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      lvl_q        <= lvl_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      mcnt_q       <= mcnt_d;
    end
  end

  // Register file and stack contents are deliberately left unreset.
  always_ff @(posedge Clock) begin
    if (!Reset && rf_we) rf_q[d_f] <= rf_wd;
    if (!Reset && push_en) stk_q[push_idx] <= ip_inc;
  end

  assign oIP              = ip_q;
  assign oLed             = led_q;
  assign oFault           = fault_q;
  assign oFaultCode       = fault_code_q;
  assign oStackLevel      = lvl_q;
  assign out_if.oOutData  = out_dat_q;
  assign out_if.oOutValid = out_vld_q;

endmodule

// File: tb/tb_mini_alu_core_p.sv
// Directed bench for mini_alu_core_p: a 16-bit core plus an 8-bit-data core for the narrow multiply.
module tb_mini_alu_core_p;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic rst8  = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 Clock = ~Clock;

  logic [27:0] rom  [256];
  logic [27:0] rom8 [256];

  logic [15:0] oIP, oIP8;
  logic [27:0] instr, instr8;
  logic [7:0]  oLed, oLed8;
  logic        oFault, oFault8;
  logic [1:0]  oFaultCode, oFaultCode8;
  logic [2:0]  oStackLevel, oStackLevel8;

  assign instr  = rom[oIP[7:0]];
  assign instr8 = rom8[oIP8[7:0]];

  mini_alu_core_p_if #(.DATA_WIDTH(16)) out_if ();
  mini_alu_core_p_if #(.DATA_WIDTH(8))  out8_if ();

  mini_alu_core_p dut (
    .Clock(Clock), .Reset(Reset), .oIP(oIP), .iInstruction(instr), .oLed(oLed),
    .oFault(oFault), .oFaultCode(oFaultCode), .oStackLevel(oStackLevel), .out_if(out_if)
  );

  mini_alu_core_p #(.DATA_WIDTH(8)) dut8 (
    .Clock(Clock), .Reset(rst8), .oIP(oIP8), .iInstruction(instr8), .oLed(oLed8),
    .oFault(oFault8), .oFaultCode(oFaultCode8), .oStackLevel(oStackLevel8), .out_if(out8_if)
  );

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic start();
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
  endtask

  logic [15:0] exp_ip  [8] = '{16'h10, 16'h20, 16'h30, 16'h40, 16'h31, 16'h21, 16'h11, 16'h01};
  logic [2:0]  exp_lvl [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  initial begin
    out_if.iOutReady  = 1'b1;
    out8_if.iOutReady = 1'b1;
    for (int i = 0; i < 256; i++) rom8[i] = '0;

    // Arithmetic, LED timing, SUB wrap observed through OUTR
    clear_rom();
    rom[0] = ins(4'd3, 8'd1, 8'h00, 8'h05);
    rom[1] = ins(4'd3, 8'd2, 8'h00, 8'h03);
    rom[2] = ins(4'd1, 8'd3, 8'd1, 8'd2);
    rom[3] = ins(4'd2, 8'd4, 8'd2, 8'd1);
    rom[4] = ins(4'd8, 8'd0, 8'd3, 8'd0);
    rom[5] = ins(4'd11, 8'd0, 8'd4, 8'd0);
    rom[6] = ins(4'd5, 8'd6, 8'd0, 8'd0);
    start();
    chk("rst_ip", oIP, 0);
    chk("rst_led", oLed, 0);
    chk("rst_vld", out_if.oOutValid, 0);
    chk("rst_dat", out_if.oOutData, 0);
    chk("rst_fault", oFault, 0);
    chk("rst_code", oFaultCode, 0);
    chk("rst_lvl", oStackLevel, 0);
    tick(9);
    chk("led_early", oLed, 0);
    tick(1);
    chk("led_add", oLed, 8'h08);
    tick(2);
    chk("sub_vld", out_if.oOutValid, 1);
    chk("sub_dat", out_if.oOutData, 16'hFFFE);
    tick(1);
    chk("sub_hs_vld", out_if.oOutValid, 0);
    chk("sub_hs_ip", oIP, 16'h6);

    // BLE taken then not taken
    clear_rom();
    rom[0]     = ins(4'd3, 8'd1, 8'h00, 8'h03);
    rom[1]     = ins(4'd3, 8'd2, 8'h00, 8'h07);
    rom[2]     = ins(4'd4, 8'h20, 8'd1, 8'd2);
    rom[8'h20] = ins(4'd4, 8'h40, 8'd2, 8'd1);
    rom[8'h21] = ins(4'd5, 8'h21, 8'd0, 8'd0);
    start();
    tick(6);
    chk("ble_taken", oIP, 16'h20);
    tick(2);
    chk("ble_not", oIP, 16'h21);

    // Nested CALL x4 then RET x4
    clear_rom();
    rom[8'h00] = ins(4'd6, 8'h10, 8'd0, 8'd0);
    rom[8'h10] = ins(4'd6, 8'h20, 8'd0, 8'd0);
    rom[8'h20] = ins(4'd6, 8'h30, 8'd0, 8'd0);
    rom[8'h30] = ins(4'd6, 8'h40, 8'd0, 8'd0);
    rom[8'h40] = ins(4'd7, 8'h00, 8'd0, 8'd0);
    rom[8'h31] = ins(4'd7, 8'h00, 8'd0, 8'd0);
    rom[8'h21] = ins(4'd7, 8'h00, 8'd0, 8'd0);
    rom[8'h11] = ins(4'd7, 8'h00, 8'd0, 8'd0);
    rom[8'h01] = ins(4'd5, 8'h01, 8'd0, 8'd0);
    start();
    for (int i = 0; i < 8; i++) begin
      tick(2);
      chk($sformatf("call_ip%0d", i), oIP, exp_ip[i]);
      chk($sformatf("call_lvl%0d", i), oStackLevel, exp_lvl[i]);
    end
    chk("call_nofault", oFault, 0);

    // Fifth nested CALL overflows
    clear_rom();
    rom[8'h00] = ins(4'd6, 8'h10, 8'd0, 8'd0);
    rom[8'h10] = ins(4'd6, 8'h20, 8'd0, 8'd0);
    rom[8'h20] = ins(4'd6, 8'h30, 8'd0, 8'd0);
    rom[8'h30] = ins(4'd6, 8'h40, 8'd0, 8'd0);
    rom[8'h40] = ins(4'd6, 8'h50, 8'd0, 8'd0);
    start();
    tick(8);
    chk("ovf_pre_fault", oFault, 0);
    tick(2);
    chk("ovf_fault", oFault, 1);
    chk("ovf_code", oFaultCode, 2'b01);
    chk("ovf_ip", oIP, 16'h40);
    chk("ovf_lvl", oStackLevel, 4);
    tick(5);
    chk("ovf_ip_frozen", oIP, 16'h40);
    chk("ovf_sticky", oFault, 1);

    // RET at level 0
    clear_rom();
    rom[0] = ins(4'd7, 8'd0, 8'd0, 8'd0);
    start();
    chk("unf_rst_fault", oFault, 0);
    tick(2);
    chk("unf_fault", oFault, 1);
    chk("unf_code", oFaultCode, 2'b10);
    chk("unf_ip", oIP, 0);

    // Illegal opcode 13
    clear_rom();
    rom[0] = ins(4'd13, 8'd0, 8'd0, 8'd0);
    start();
    tick(2);
    chk("ill_code", oFaultCode, 2'b11);
    chk("ill_ip", oIP, 0);

    // MUL 300*250 mod 2^16 = 9464, committed 18 cycles after its FETCH starts
    clear_rom();
    rom[0] = ins(4'd3, 8'd1, 8'h01, 8'h2C);
    rom[1] = ins(4'd3, 8'd2, 8'h00, 8'hFA);
    rom[2] = ins(4'd3, 8'd3, 8'h00, 8'h00);
    rom[3] = ins(4'd9, 8'd3, 8'd1, 8'd2);
    rom[4] = ins(4'd11, 8'd0, 8'd3, 8'd0);
    rom[5] = ins(4'd5, 8'd5, 8'd0, 8'd0);
    start();
    chk("mul_rst_fault", oFault, 0);
    tick(23);
    chk("mul_ip_busy", oIP, 16'h3);
    chk("mul_r3_busy", dut.rf_q[3], 0);
    tick(1);
    chk("mul_ip_done", oIP, 16'h4);
    chk("mul_r3_done", dut.rf_q[3], 16'd9464);
    tick(2);
    chk("mul_out_vld", out_if.oOutValid, 1);
    chk("mul_out_dat", out_if.oOutData, 16'd9464);

    // Reset during MUL cycle 5
    start();
    tick(12);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk("mulrst_ip", oIP, 0);
    chk("mulrst_vld", out_if.oOutValid, 0);
    chk("mulrst_led", oLed, 0);
    chk("mulrst_r3", dut.rf_q[3], 0);

    // OUTR with 3 stall cycles
    clear_rom();
    rom[0] = ins(4'd3, 8'd5, 8'h00, 8'h41);
    rom[1] = ins(4'd8, 8'd0, 8'd5, 8'd0);
    rom[2] = ins(4'd11, 8'd0, 8'd5, 8'd0);
    rom[3] = ins(4'd5, 8'd3, 8'd0, 8'd0);
    out_if.iOutReady = 1'b0;
    start();
    tick(4);
    chk("outw_led", oLed, 8'h41);
    tick(1);
    chk("outw_pre_vld", out_if.oOutValid, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk($sformatf("outw_vld%0d", i), out_if.oOutValid, 1);
      chk($sformatf("outw_dat%0d", i), out_if.oOutData, 16'h41);
    end
    out_if.iOutReady = 1'b1;
    tick(1);
    chk("outw_hs_vld", out_if.oOutValid, 0);
    chk("outw_hs_ip", oIP, 16'h3);

    // Reset while waiting in OUTW with valid high
    out_if.iOutReady = 1'b0;
    start();
    tick(7);
    chk("outrst_pre_vld", out_if.oOutValid, 1);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk("outrst_ip", oIP, 0);
    chk("outrst_vld", out_if.oOutValid, 0);
    chk("outrst_led", oLed, 0);
    chk("outrst_dat", out_if.oOutData, 0);

    // DATA_WIDTH=8: 20*13 = 260 -> 4
    rom8[0] = ins(4'd3, 8'd1, 8'h00, 8'd20);
    rom8[1] = ins(4'd3, 8'd2, 8'h00, 8'd13);
    rom8[2] = ins(4'd9, 8'd3, 8'd1, 8'd2);
    rom8[3] = ins(4'd11, 8'd0, 8'd3, 8'd0);
    rom8[4] = ins(4'd5, 8'd4, 8'd0, 8'd0);
    rst8 = 1'b0;
    tick(13);
    chk("mul8_ip_busy", oIP8, 16'h2);
    tick(1);
    chk("mul8_ip_done", oIP8, 16'h3);
    tick(2);
    chk("mul8_vld", out8_if.oOutValid, 1);
    chk("mul8_dat", out8_if.oOutData, 8'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
